// File: rtl/robo_pkg.sv
// Shared definitions for the wheel-motor sequencer.
// Contents: state encoding, turn-direction codes, default timing constants,
// the motor drive bundle type and helpers used by the sequencer.
package robo_pkg;

    // State codes, also presented on the St output.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FWD   = 3'd1;
    localparam logic [2:0] ST_DEAD  = 3'd2;
    localparam logic [2:0] ST_REV   = 3'd3;
    localparam logic [2:0] ST_TURN  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    // Turn direction codes.
    localparam logic TURN_R = 1'b0;
    localparam logic TURN_L = 1'b1;

    // Default timing, in clock cycles.
    localparam int unsigned DEF_DEB_CYCLES  = 4;
    localparam int unsigned DEF_DEAD_CYCLES = 8;
    localparam int unsigned DEF_REV_CYCLES  = 1000;
    localparam int unsigned DEF_TURN_CYCLES = 600;

    // One bit per motor drive line.
    typedef struct packed {
        logic re;    // left forward
        logic rd;    // right forward
        logic r_re;  // left reverse
        logic r_rd;  // right reverse
    } motor_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Motor drive for a given state; dir only matters in TURN.
    // No state ever drives both directions on one side.
    function automatic motor_t motor_decode(input logic [2:0] st, input logic dir);
        motor_t m;
        m = '0;
        case (st)
            ST_FWD: begin
                m.re = 1'b1;
                m.rd = 1'b1;
            end
            ST_REV: begin
                m.r_re = 1'b1;
                m.r_rd = 1'b1;
            end
            ST_TURN: begin
                if (dir == TURN_R) begin
                    m.re   = 1'b1;
                    m.r_rd = 1'b1;
                end else begin
                    m.rd   = 1'b1;
                    m.r_re = 1'b1;
                end
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Sensor conditioning: 2-flop synchroniser followed by a debouncer.
// Ports:
//   Clk   in  system clock, rising edge
//   Rst_n in  asynchronous active-low reset
//   din   in  raw asynchronous sensor level
//   dout  out accepted sensor level
// A new level is accepted after DEB_CYCLES consecutive equal synchronised samples.
// dout presents the accepted level as it will be after the coming edge, so a
// registered consumer reacts 2+DEB_CYCLES edges after din changes.
module sensor_debounce
    import robo_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts consecutive samples that differ from the accepted level;
    // any sample agreeing with it restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign dout = level_d;

endmodule

// File: rtl/motor_sequencer.sv
// Timed wheel-motor sequencer: forward, reverse on a front obstacle, turn away,
// resume forward, with an all-off dead time between every direction change.
// Ports:
//   Clk, Rst_n         clock (rising edge), asynchronous active-low reset
//   Liga               system enable (synchronous level)
//   Pre                error condition (synchronous level)
//   E, D, F, A         raw obstacle sensors left/right/front/rear (asynchronous)
//   Re, Rd             left/right forward drive
//   R_Re, R_Rd         left/right reverse drive
//   Erro               fault indication
//   Busy               in DEAD, REV or TURN
//   St                 state code (IDLE=0 FWD=1 DEAD=2 REV=3 TURN=4 FAULT=5)
module motor_sequencer
    import robo_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int unsigned REV_CYCLES  = DEF_REV_CYCLES,
    parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int unsigned CNT_W       = $clog2(max3(DEAD_CYCLES, REV_CYCLES, TURN_CYCLES) + 1)
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Liga,
    input  logic       Pre,
    input  logic       E,
    input  logic       D,
    input  logic       F,
    input  logic       A,
    output logic       Re,
    output logic       Rd,
    output logic       R_Re,
    output logic       R_Rd,
    output logic       Erro,
    output logic       Busy,
    output logic [2:0] St
);

    // ------------------------------------------------------------------
    // Sensor conditioning
    // ------------------------------------------------------------------
    logic e_db, d_db, f_db, a_db;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_e (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (E),
        .dout (e_db)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (D),
        .dout (d_db)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_f (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (F),
        .dout (f_db)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .din  (A),
        .dout (a_db)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [2:0]       nxt_q, nxt_d;    // state to enter when DEAD expires
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;    // direction of the current/next TURN
    logic             tog_q, tog_d;    // alternates ambiguous turn decisions
    motor_t           motor_q, motor_d;
    logic             busy_q, busy_d;
    logic             erro_q, erro_d;

    logic dead_done, rev_done, turn_done;
    logic timed;

    assign dead_done = (cnt_q == CNT_W'(DEAD_CYCLES - 1));
    assign rev_done  = (cnt_q == CNT_W'(REV_CYCLES - 1));
    assign turn_done = (cnt_q == CNT_W'(TURN_CYCLES - 1));
    assign timed     = (state_q == ST_DEAD) || (state_q == ST_REV) || (state_q == ST_TURN);

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        dir_d   = dir_q;
        tog_d   = tog_q;

        if (!Liga) begin
            state_d = ST_IDLE;
        end else if (Pre) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    nxt_d   = ST_FWD;
                end
                ST_FWD: begin
                    if (f_db) begin
                        state_d = ST_DEAD;
                        nxt_d   = ST_REV;
                    end
                end
                ST_DEAD: begin
                    // nxt_q was fixed on entry; sensors are not consulted here.
                    if (dead_done) begin
                        state_d = nxt_q;
                    end
                end
                ST_REV: begin
                    if (a_db || rev_done) begin
                        state_d = ST_DEAD;
                        nxt_d   = ST_TURN;
                        // Turn away from the side that sees an obstacle.
                        if (e_db && !d_db) begin
                            dir_d = TURN_R;
                        end else if (d_db && !e_db) begin
                            dir_d = TURN_L;
                        end else begin
                            dir_d = tog_q;
                            tog_d = ~tog_q;
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_done) begin
                        state_d = ST_DEAD;
                        nxt_d   = ST_FWD;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Counter restarts on every state change; saturates rather than wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (timed && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        motor_d = motor_decode(state_d, dir_d);
        busy_d  = (state_d == ST_DEAD) || (state_d == ST_REV) || (state_d == ST_TURN);
        erro_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            nxt_q   <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= TURN_R;
            tog_q   <= TURN_R;
            motor_q <= '0;
            busy_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            tog_q   <= tog_d;
            motor_q <= motor_d;
            busy_q  <= busy_d;
            erro_q  <= erro_d;
        end
    end

    assign Re   = motor_q.re;
    assign Rd   = motor_q.rd;
    assign R_Re = motor_q.r_re;
    assign R_Rd = motor_q.r_rd;
    assign Busy = busy_q;
    assign Erro = erro_q;
    assign St   = state_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Randomised scoreboard bench for motor_sequencer with short timing parameters.
module tb_motor_sequencer;

    localparam int DEB  = 2;
    localparam int DEAD = 2;
    localparam int REV  = 8;
    localparam int TURN = 6;

    localparam int S_IDLE = 0, S_FWD = 1, S_DEAD = 2, S_REV = 3, S_TURN = 4, S_FAULT = 5;

    logic       Clk, Rst_n, Liga, Pre, E, D, F, A;
    logic       Re, Rd, R_Re, R_Rd, Erro, Busy;
    logic [2:0] St;

    motor_sequencer #(
        .DEB_CYCLES (DEB),
        .DEAD_CYCLES(DEAD),
        .REV_CYCLES (REV),
        .TURN_CYCLES(TURN)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Liga (Liga),
        .Pre  (Pre),
        .E    (E),
        .D    (D),
        .F    (F),
        .A    (A),
        .Re   (Re),
        .Rd   (Rd),
        .R_Re (R_Re),
        .R_Rd (R_Rd),
        .Erro (Erro),
        .Busy (Busy),
        .St   (St)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] st;
        logic       re;
        logic       rd;
        logic       rre;
        logic       rrd;
        logic       erro;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   pushes = 0;

    // ------------------------------------------------------------------
    // Reference model: accepted sensor levels, state with a remaining-time
    // countdown, and the pending turn choice.
    // ------------------------------------------------------------------
    int m_st, m_nxt, m_rem;
    bit m_dir_left, m_tog_left;
    bit lvl [4];         // accepted levels: 0=E 1=D 2=F 3=A
    bit hist[4][0:15];   // hist[s][k]: raw input k cycles ago

    function automatic int duration(input int s);
        case (s)
            S_DEAD:  return DEAD;
            S_REV:   return REV;
            S_TURN:  return TURN;
            default: return 0;
        endcase
    endfunction

    task automatic go(input int s);
        m_st  = s;
        m_rem = duration(s);
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_nxt = S_IDLE; m_rem = 0;
        m_dir_left = 1'b0; m_tog_left = 1'b0;
        for (int s = 0; s < 4; s++) begin
            lvl[s] = 1'b0;
            for (int k = 0; k < 16; k++) hist[s][k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit liga, input bit pre, input bit [3:0] raw,
                              output exp_t e);
        // A level is seen at this edge once the DEB samples that are already
        // through the synchroniser (inputs 2..DEB+1 cycles back) all agree.
        for (int s = 0; s < 4; s++) begin
            bit agree;
            for (int k = 15; k > 0; k--) hist[s][k] = hist[s][k-1];
            hist[s][0] = raw[s];
            agree = 1'b1;
            for (int k = 2; k < DEB + 2; k++) if (hist[s][k] != hist[s][2]) agree = 1'b0;
            if (agree) lvl[s] = hist[s][2];
        end

        if (!liga) go(S_IDLE);
        else if (pre) go(S_FAULT);
        else begin
            case (m_st)
                S_IDLE: begin m_nxt = S_FWD; go(S_DEAD); end
                S_FWD:  if (lvl[2]) begin m_nxt = S_REV; go(S_DEAD); end
                S_DEAD: begin
                    m_rem--;
                    if (m_rem == 0) go(m_nxt);
                end
                S_REV: begin
                    m_rem--;
                    if (m_rem == 0 || lvl[3]) begin
                        if (lvl[0] && !lvl[1]) m_dir_left = 1'b0;
                        else if (lvl[1] && !lvl[0]) m_dir_left = 1'b1;
                        else begin
                            m_dir_left = m_tog_left;
                            m_tog_left = !m_tog_left;
                        end
                        m_nxt = S_TURN;
                        go(S_DEAD);
                    end
                end
                S_TURN: begin
                    m_rem--;
                    if (m_rem == 0) begin m_nxt = S_FWD; go(S_DEAD); end
                end
                default: ;
            endcase
        end

        e      = '0;
        e.st   = 3'(m_st);
        e.erro = (m_st == S_FAULT);
        e.busy = (m_st == S_DEAD) || (m_st == S_REV) || (m_st == S_TURN);
        if (m_st == S_FWD) begin e.re = 1'b1; e.rd = 1'b1; end
        if (m_st == S_REV) begin e.rre = 1'b1; e.rrd = 1'b1; end
        if (m_st == S_TURN) begin
            if (m_dir_left) begin e.rd = 1'b1; e.rre = 1'b1; end
            else begin e.re = 1'b1; e.rrd = 1'b1; end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus: each input holds a random value for a random time.
    // ------------------------------------------------------------------
    bit [3:0] raw;
    int       hold[4];
    int       pct[4] = '{50, 50, 35, 15};
    bit       liga_v, pre_v;
    int       liga_hold, pre_hold;

    task automatic cycle_body();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            if (hold[s] == 0) begin
                raw[s]  = ($urandom_range(0, 99) < pct[s]);
                hold[s] = $urandom_range(1, 12);
            end else hold[s]--;
        end
        if (liga_hold == 0) begin
            liga_v    = !liga_v;
            liga_hold = liga_v ? $urandom_range(80, 400) : $urandom_range(1, 4);
        end else liga_hold--;
        if (pre_hold == 0) begin
            pre_v    = !pre_v;
            pre_hold = pre_v ? $urandom_range(1, 20) : $urandom_range(150, 600);
        end else pre_hold--;

        Liga = liga_v; Pre = pre_v;
        E = raw[0]; D = raw[1]; F = raw[2]; A = raw[3];
        model_step(liga_v, pre_v, raw, e);
        exp_q.push_back(e);
        pushes++;
        if (pushes >= 2) mon_en = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [2:0] prev_st = 3'd0;

    always @(negedge Clk) begin
        if (mon_en) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({St, Re, Rd, R_Re, R_Rd, Erro, Busy} != e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got St=%0d Re=%b Rd=%b R_Re=%b R_Rd=%b Erro=%b Busy=%b want St=%0d Re=%b Rd=%b R_Re=%b R_Rd=%b Erro=%b Busy=%b",
                             $time, St, Re, Rd, R_Re, R_Rd, Erro, Busy,
                             e.st, e.re, e.rd, e.rre, e.rrd, e.erro, e.busy);
                end
            end
            checks++;
            if ((Re && R_Re) || (Rd && R_Rd)) begin
                errors++;
                $display("FAIL shoot_through t=%0t: got Re=%b R_Re=%b Rd=%b R_Rd=%b want no side both",
                         $time, Re, R_Re, Rd, R_Rd);
            end
            checks++;
            if ((prev_st == 3'd1 && (St == 3'd3 || St == 3'd4)) ||
                ((prev_st == 3'd3 || prev_st == 3'd4) && St == 3'd1)) begin
                errors++;
                $display("FAIL dead_time t=%0t: got St %0d->%0d want DEAD in between",
                         $time, prev_st, St);
            end
            prev_st = St;
        end else begin
            prev_st = 3'd0;
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({St, Re, Rd, R_Re, R_Rd, Erro, Busy} != '0) begin
            errors++;
            $display("FAIL %s t=%0t: got St=%0d Re=%b Rd=%b R_Re=%b R_Rd=%b Erro=%b Busy=%b want all 0",
                     name, $time, St, Re, Rd, R_Re, R_Rd, Erro, Busy);
        end
    endtask

    task automatic release_reset();
        @(posedge Clk);
        #1;
        Rst_n  = 1'b1;
        pushes = 0;
        cycle_body();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        Rst_n = 1'b0; Liga = 1'b0; Pre = 1'b0;
        E = 1'b0; D = 1'b0; F = 1'b0; A = 1'b0;
        raw = '0;
        for (int s = 0; s < 4; s++) hold[s] = 0;
        liga_v = 1'b0; liga_hold = 2;
        pre_v = 1'b0; pre_hold = 200;
        model_reset();

        #12;
        check_zero("reset_state");
        release_reset();
        repeat (3000) begin
            @(posedge Clk);
            #1;
            cycle_body();
        end

        // Run until the model is in TURN, then reset asynchronously mid-cycle.
        n = 0;
        while (m_st != S_TURN && n < 5000) begin
            @(posedge Clk);
            #1;
            cycle_body();
            n++;
        end
        checks++;
        if (m_st != S_TURN) begin
            errors++;
            $display("FAIL reach_turn: got model state %0d want %0d within 5000 cycles",
                     m_st, S_TURN);
        end
        @(posedge Clk);
        #3;
        Rst_n  = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_reset_mid_turn");
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_zero("reset_hold");
        release_reset();
        repeat (3000) begin
            @(posedge Clk);
            #1;
            cycle_body();
        end

        @(negedge Clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
